vm_change: RTL

Change dispenser for the vending machine: the pay-out side of the coin interface the `vm` FSM consumes. Accepts a change amount in 5-unit steps and drives a coin ejector with the same 2-bit coin encoding `vm` accepts. Pays out greedily from two restockable coin inventories and reports completion, shortfall and ejector timeout. It sits between the vending controller, which requests change, and the mechanical ejector.

---
 rtl/vm_pkg.sv | 30 +++
 rtl/vm_change_if.sv | 33 +++
 rtl/vm_coin_stock.sv | 31 +++
 rtl/vm_change.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin codes and vm_change state encoding
// Purpose: coin encoding common to the vending FSM and the change dispenser,
//          the dispenser state type, and a coin-to-units helper.
// Ports:   none (package).
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        VMC_IDLE  = 2'd0,
        VMC_PICK  = 2'd1,
        VMC_EJECT = 2'd2,
        VMC_FIN   = 2'd3
    } vmc_state_e;

    // Value of a coin code in units of 5.
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        logic [1:0] units;
        units = 2'd0;
        if (coin == COIN_10) begin
            units = 2'd2;
        end else if (coin == COIN_5) begin
            units = 2'd1;
        end
        return units;
    endfunction

endpackage

// File: rtl/vm_change_if.sv
// rtl/vm_change_if.sv - request, restock and ejector signals of vm_change
// Purpose: bundles the change-request handshake, restock strobe, coin ejector
//          handshake and completion status.
// Ports:   master = requester/ejector side, slave = vm_change.
//          req_valid/req_amt/req_ready, load/load_coin,
//          coin_out/coin_valid/coin_ack, done/short/timeout/rem_out.
interface vm_change_if #(
    parameter int AMT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             load;
    logic [1:0]       load_coin;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic             coin_ack;
    logic             done;
    logic             short;
    logic             timeout;
    logic [AMT_W-1:0] rem_out;

    modport master (
        output req_valid, req_amt, load, load_coin, coin_ack,
        input  req_ready, coin_out, coin_valid, done, short, timeout, rem_out
    );

    modport slave (
        input  req_valid, req_amt, load, load_coin, coin_ack,
        output req_ready, coin_out, coin_valid, done, short, timeout, rem_out
    );

endinterface

// File: rtl/vm_coin_stock.sv
// rtl/vm_coin_stock.sv - saturating up/down coin inventory counter
// Purpose: holds the number of coins of one denomination.
// Ports:   clk, rst (async active-low), inc, dec, count, empty.
module vm_coin_stock #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         empty
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != '1) begin
                count <= count + W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/vm_change.sv
// rtl/vm_change.sv - greedy change dispenser driving a coin ejector
// Purpose: pays a requested amount (units of 5) from ten and five inventories,
//          tens first, and reports done / short / timeout / unpaid remainder.
// Ports:   clk, rst (async active-low), bus (vm_change_if.slave).
// Config:  VM_CHANGE_TIMEOUT_EN builds the ejector ack watchdog (TIMEOUT cycles).
module vm_change
    import vm_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    vm_change_if.slave  bus
);

    vmc_state_e       state;
    logic [AMT_W-1:0] rem;
    logic [1:0]       coin_out_q;
    logic             coin_valid_q;
    logic             done_q;
    logic             short_q;
    logic             timeout_q;
    logic [AMT_W-1:0] rem_out_q;

    logic             inc5, inc10, dec5, dec10;
    logic             empty5, empty10;
    logic [CNT_W-1:0] inv5, inv10;
    logic             in_idle, acked;

    assign in_idle = (state == VMC_IDLE);
    assign acked   = (state == VMC_EJECT) && coin_valid_q && bus.coin_ack;

    // Restock only while idle so the inventory cannot move under a payout.
    assign inc5  = in_idle && bus.load && (bus.load_coin == COIN_5);
    assign inc10 = in_idle && bus.load && (bus.load_coin == COIN_10);
    assign dec5  = acked && (coin_out_q == COIN_5);
    assign dec10 = acked && (coin_out_q == COIN_10);

    vm_coin_stock #(.W(CNT_W)) u_stock5 (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc5),
        .dec   (dec5),
        .count (inv5),
        .empty (empty5)
    );

    vm_coin_stock #(.W(CNT_W)) u_stock10 (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc10),
        .dec   (dec10),
        .count (inv10),
        .empty (empty10)
    );

    // Control only needs the empty flags; the levels stay visible for debug.
    logic unused_levels;
    assign unused_levels = ^{inv5, inv10};

`ifdef VM_CHANGE_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMR_W-1:0] tmr;
`else
    // The watchdog length only matters when the watchdog is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= VMC_IDLE;
            rem          <= '0;
            coin_out_q   <= COIN_NONE;
            coin_valid_q <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            timeout_q    <= 1'b0;
            rem_out_q    <= '0;
`ifdef VM_CHANGE_TIMEOUT_EN
            tmr          <= '0;
`endif
        end else begin
            case (state)
                VMC_IDLE: begin
                    if (bus.req_valid) begin
                        rem       <= bus.req_amt;
                        short_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        rem_out_q <= '0;
                        state     <= VMC_PICK;
                    end
                end

                VMC_PICK: begin
                    if (rem == '0) begin
                        done_q    <= 1'b1;
                        rem_out_q <= rem;
                        state     <= VMC_FIN;
                    end else if ((rem >= AMT_W'(2)) && !empty10) begin
                        coin_out_q   <= COIN_10;
                        coin_valid_q <= 1'b1;
                        state        <= VMC_EJECT;
`ifdef VM_CHANGE_TIMEOUT_EN
                        tmr          <= '0;
`endif
                    end else if (!empty5) begin
                        coin_out_q   <= COIN_5;
                        coin_valid_q <= 1'b1;
                        state        <= VMC_EJECT;
`ifdef VM_CHANGE_TIMEOUT_EN
                        tmr          <= '0;
`endif
                    end else begin
                        // Nothing left that fits: report what is still owed.
                        short_q   <= 1'b1;
                        done_q    <= 1'b1;
                        rem_out_q <= rem;
                        state     <= VMC_FIN;
                    end
                end

                VMC_EJECT: begin
                    if (bus.coin_ack) begin
                        rem          <= rem - AMT_W'(coin_units(coin_out_q));
                        coin_out_q   <= COIN_NONE;
                        coin_valid_q <= 1'b0;
                        state        <= VMC_PICK;
                    end
`ifdef VM_CHANGE_TIMEOUT_EN
                    else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                        // Abandoned coin is not counted: rem and stock stay put.
                        coin_out_q   <= COIN_NONE;
                        coin_valid_q <= 1'b0;
                        timeout_q    <= 1'b1;
                        done_q       <= 1'b1;
                        rem_out_q    <= rem;
                        state        <= VMC_FIN;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
`endif
                end

                VMC_FIN: begin
                    done_q <= 1'b0;
                    state  <= VMC_IDLE;
                end

                default: begin
                    state <= VMC_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = in_idle;
    assign bus.coin_out   = coin_out_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.done       = done_q;
    assign bus.short      = short_q;
    assign bus.timeout    = timeout_q;
    assign bus.rem_out    = rem_out_q;

endmodule
